// File: rtl/scrypt_ram_seq.sv
// Scratchpad RAM sequencer for one scrypt hash: FILL writes N core words to
// addresses 0..N-1, then MIX serves N reads at core-supplied indices.
module scrypt_ram_seq #(
    parameter int ADDRBITS = 10,
    parameter int DW       = 256
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                wr_valid_i,
    input  logic [DW-1:0]       wr_data_i,
    output logic                wr_ready_o,
    input  logic                idx_valid_i,
    input  logic [ADDRBITS-1:0] idx_i,
    output logic                idx_ready_o,
    output logic                rd_valid_o,
    output logic [DW-1:0]       rd_data_o,
    input  logic                rd_ready_i,
    output logic [ADDRBITS-1:0] ram_address_o,
    output logic [DW-1:0]       ram_data_o,
    output logic                ram_wren_o,
    input  logic [DW-1:0]       ram_q_i
);

    localparam int CW = ADDRBITS + 1;
    localparam logic [CW-1:0] N_WORDS = CW'(1) << ADDRBITS;
    localparam logic [CW-1:0] LAST    = N_WORDS - CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_MIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [CW-1:0]       icnt_q, icnt_d;
    logic [CW-1:0]       rcnt_q, rcnt_d;
    logic [ADDRBITS-1:0] addr_q, addr_d;
    logic                rd_valid_q, rd_valid_d;

    logic wr_hs, idx_rdy, idx_hs, rd_hs;

    always_comb begin
        wr_hs   = (state_q == S_FILL) && wr_valid_i;
        rd_hs   = (state_q == S_MIX) && rd_valid_q && rd_ready_i;
        idx_rdy = (state_q == S_MIX) && (icnt_q < N_WORDS) && (!rd_valid_q || rd_ready_i);
        idx_hs  = idx_rdy && idx_valid_i;
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign wr_ready_o  = (state_q == S_FILL);
    assign idx_ready_o = idx_rdy;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = ram_q_i;
    assign ram_data_o  = wr_data_i;
    assign ram_wren_o  = wr_hs;

    // The RAM latches its address every cycle, so outside a handshake we
    // replay the last index to keep ram_q (and rd_data) stable during stalls.
    always_comb begin
        if (wr_hs)
            ram_address_o = wcnt_q[ADDRBITS-1:0];
        else if (idx_hs)
            ram_address_o = idx_i;
        else
            ram_address_o = addr_q;
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        icnt_d     = icnt_q;
        rcnt_d     = rcnt_q;
        addr_d     = addr_q;
        rd_valid_d = rd_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FILL;
                    wcnt_d  = '0;
                end
            end
            S_FILL: begin
                if (wr_hs) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == LAST) begin
                        state_d = S_MIX;
                        icnt_d  = '0;
                        rcnt_d  = '0;
                    end
                end
            end
            S_MIX: begin
                if (idx_hs) begin
                    icnt_d     = icnt_q + CW'(1);
                    addr_d     = idx_i;
                    rd_valid_d = 1'b1;
                end else if (rd_hs) begin
                    rd_valid_d = 1'b0;
                end
                if (rd_hs) begin
                    rcnt_d = rcnt_q + CW'(1);
                    if (rcnt_q == LAST)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rd_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state logic decided above.
        if (abort_i) begin
            state_d    = S_IDLE;
            wcnt_d     = '0;
            icnt_d     = '0;
            rcnt_d     = '0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            icnt_q     <= '0;
            rcnt_q     <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            icnt_q     <= icnt_d;
            rcnt_q     <= rcnt_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_scrypt_ram_seq.sv
// Directed bench for scrypt_ram_seq with ADDRBITS=3 and a behavioural
// registered-address RAM attached to the RAM port.
module tb_scrypt_ram_seq;

    localparam int AB = 3;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, wr_valid, idx_valid, rd_ready;
    logic [DW-1:0] wr_data;
    logic [AB-1:0] idx;
    logic          busy, done, wr_ready, idx_ready, rd_valid, ram_wren;
    logic [DW-1:0] rd_data, ram_data, ram_q;
    logic [AB-1:0] ram_address;

    int tests_run = 0;
    int tests_failed = 0;

    scrypt_ram_seq #(.ADDRBITS(AB), .DW(DW)) dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .idx_valid_i   (idx_valid),
        .idx_i         (idx),
        .idx_ready_o   (idx_ready),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .rd_ready_i    (rd_ready),
        .ram_address_o (ram_address),
        .ram_data_o    (ram_data),
        .ram_wren_o    (ram_wren),
        .ram_q_i       (ram_q)
    );

    always #5 clk = ~clk;

    // Scratchpad RAM: address registered each cycle, q valid one cycle later.
    logic [DW-1:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    function automatic logic [DW-1:0] w1(input int k);
        return DW'(32'hC0DE_0000 + k);
    endfunction
    function automatic logic [DW-1:0] w2(input int k);
        return DW'(32'hBEEF_0000 + k);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int seq [8] = '{7, 0, 3, 3, 5, 1, 6, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; start = 0; abort = 0; wr_valid = 0; idx_valid = 0;
        rd_ready = 0; wr_data = '0; idx = '0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_busy",      DW'(busy),        DW'(0));
        check("rst_done",      DW'(done),        DW'(0));
        check("rst_wr_ready",  DW'(wr_ready),    DW'(0));
        check("rst_idx_ready", DW'(idx_ready),   DW'(0));
        check("rst_rd_valid",  DW'(rd_valid),    DW'(0));
        check("rst_wren",      DW'(ram_wren),    DW'(0));
        check("rst_addr",      DW'(ram_address), DW'(0));
        step();
        rst_n = 1'b1;
        step();

        // Hash 1: FILL with wr_valid held
        start = 1; step(); start = 0;
        check("fill_busy",     DW'(busy),     DW'(1));
        check("fill_wr_ready", DW'(wr_ready), DW'(1));
        for (int k = 0; k < 8; k++) begin
            wr_valid = 1; wr_data = w1(k);
            #1;
            $display("[TB] write addr=%0d data=%0h", ram_address, ram_data);
            check("fill_wren", DW'(ram_wren),    DW'(1));
            check("fill_addr", DW'(ram_address), DW'(k));
            check("fill_data", ram_data,         w1(k));
            step();
        end
        wr_valid = 0;
        #1;
        check("mix_wr_ready",  DW'(wr_ready),  DW'(0));
        check("mix_idx_ready", DW'(idx_ready), DW'(1));
        check("mix_wren",      DW'(ram_wren),  DW'(0));

        // MIX back-to-back with rd_ready high
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            idx_valid = 1; idx = AB'(seq[i]);
            #1;
            check("mix_idx_ready", DW'(idx_ready),   DW'(1));
            check("mix_addr",      DW'(ram_address), DW'(seq[i]));
            if (i == 0) begin
                check("mix_rd_valid0", DW'(rd_valid), DW'(0));
            end else begin
                $display("[TB] read idx=%0d data=%0h", seq[i-1], rd_data);
                check("mix_rd_valid", DW'(rd_valid), DW'(1));
                check("mix_rd_data",  rd_data,       w1(seq[i-1]));
            end
            step();
        end
        idx_valid = 0;
        #1;
        $display("[TB] read idx=%0d data=%0h", seq[7], rd_data);
        check("mix_last_valid", DW'(rd_valid),  DW'(1));
        check("mix_last_data",  rd_data,        w1(seq[7]));
        check("mix_idx_full",   DW'(idx_ready), DW'(0));
        check("mix_no_done",    DW'(done),      DW'(0));
        step();
        check("done_pulse",    DW'(done),     DW'(1));
        check("done_busy",     DW'(busy),     DW'(1));
        check("done_rd_valid", DW'(rd_valid), DW'(0));
        step();
        check("idle_done", DW'(done), DW'(0));
        check("idle_busy", DW'(busy), DW'(0));

        // Hash 2: FILL with toggling wr_valid, start while busy
        rd_ready = 0;
        start = 1; step(); start = 0;
        for (int c = 0; c < 16; c++) begin
            wr_valid = (c % 2 == 0);
            wr_data  = w2(c / 2);
            start    = (c == 3);
            #1;
            check("tog_wren", DW'(ram_wren), DW'(c % 2 == 0));
            if (c % 2 == 0) begin
                $display("[TB] write addr=%0d data=%0h", ram_address, ram_data);
                check("tog_addr", DW'(ram_address), DW'(c / 2));
            end
            step();
        end
        wr_valid = 0; start = 0;
        #1;
        check("tog_wcnt",      DW'(dut.wcnt_q), DW'(8));
        check("tog_idx_ready", DW'(idx_ready),  DW'(1));

        // MIX with a 3-cycle consumer stall
        rd_ready = 1; idx_valid = 1; idx = 3'd4;
        #1;
        check("stall_acc4", DW'(idx_ready), DW'(1));
        step();
        rd_ready = 0; idx = 3'd6;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_idx_ready", DW'(idx_ready),   DW'(0));
            check("stall_addr",      DW'(ram_address), DW'(4));
            check("stall_rd_valid",  DW'(rd_valid),    DW'(1));
            check("stall_rd_data",   rd_data,          w2(4));
            step();
        end
        rd_ready = 1;
        #1;
        $display("[TB] read idx=4 data=%0h", rd_data);
        check("resume_idx_ready", DW'(idx_ready),   DW'(1));
        check("resume_addr",      DW'(ram_address), DW'(6));
        check("resume_rd_data",   rd_data,          w2(4));
        step();
        idx = 3'd1;
        #1;
        $display("[TB] read idx=6 data=%0h", rd_data);
        check("resume_rd6", rd_data, w2(6));
        step();
        idx = 3'd2;
        #1;
        $display("[TB] read idx=1 data=%0h", rd_data);
        check("resume_rd1", rd_data, w2(1));
        step();

        // Abort with a read still pending
        idx_valid = 0; rd_ready = 0; abort = 1;
        #1;
        check("abort_pending", DW'(rd_valid), DW'(1));
        step();
        abort = 0;
        check("abort_busy",      DW'(busy),      DW'(0));
        check("abort_rd_valid",  DW'(rd_valid),  DW'(0));
        check("abort_done",      DW'(done),      DW'(0));
        check("abort_idx_ready", DW'(idx_ready), DW'(0));
        step();
        check("abort_done2", DW'(done), DW'(0));

        // start and abort together in IDLE
        start = 1; abort = 1; step(); start = 0; abort = 0;
        check("sa_busy", DW'(busy), DW'(0));

        // New hash restarts FILL at address 0; async reset mid-FILL
        start = 1; step(); start = 0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1; wr_data = w1(k + 8);
            #1;
            check("refill_addr", DW'(ram_address), DW'(k));
            check("refill_wren", DW'(ram_wren),    DW'(1));
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",     DW'(busy),     DW'(0));
        check("arst_wr_ready", DW'(wr_ready), DW'(0));
        check("arst_wren",     DW'(ram_wren), DW'(0));
        check("arst_rd_valid", DW'(rd_valid), DW'(0));
        step();
        rst_n = 1'b1; wr_valid = 0;
        step();
        check("arst_idle", DW'(busy), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/scrypt_ram_seq.md
Name: scrypt_ram_seq

Overview:
Sequencer for the scrypt scratchpad RAM (ram, 256-bit words, 2**ADDRBITS deep, registered read address, 1-cycle read latency). It runs the two scrypt phases for one hash. FILL writes core output words to consecutive addresses 0..N-1. MIX serves N random reads at core-supplied Integerify indices. Sits between the salsa/mix core and the RAM instance, with valid/ready handshakes on the core side.

Parameters:
ADDRBITS, 10, RAM address width; N = 2**ADDRBITS words per phase
DW, 256, data width; must match the RAM data port

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a hash; ignored unless IDLE
abort  in  1  synchronous; returns to IDLE next cycle from any state
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the N-th read is accepted
wr_valid  in  1  core has a FILL word
wr_data  in  DW  FILL word
wr_ready  out  1  high only in FILL
idx_valid  in  1  core presents a MIX index
idx  in  ADDRBITS  Integerify index j
idx_ready  out  1  index accepted this cycle when both idx_valid and idx_ready are high
rd_valid  out  1  rd_data holds V[j]
rd_data  out  DW  read word, wired from ram_q
rd_ready  in  1  core consumes rd_data
ram_address  out  ADDRBITS  to RAM address
ram_data  out  DW  to RAM data; equals wr_data
ram_wren  out  1  to RAM write enable
ram_q  in  DW  from RAM q

Behaviour:
- Reset (reset_n low, async): state IDLE. busy, done, wr_ready, idx_ready, rd_valid and ram_wren = 0. Address hold register = 0. wcnt, icnt, rcnt = 0. RAM contents untouched.
- States: IDLE, FILL, MIX, DONE. abort has priority over every transition. Abort goes to IDLE, clears counters and rd_valid, and does not pulse done.
- IDLE: start=1 -> FILL; wcnt=0.
- FILL: wr_ready=1.
  - Each wr_valid&wr_ready cycle: ram_address=wcnt, ram_wren=1 (combinational), wcnt++.
  - The handshake with wcnt==N-1 moves to MIX next cycle; icnt=rcnt=0.
  - ram_wren is never high outside a FILL handshake.
- MIX:
  - idx_ready = (icnt<N) & (!rd_valid | rd_ready). One read is outstanding at most, with full throughput when rd_ready stays high.
  - On idx handshake: ram_address=idx (combinational), the hold register captures idx, icnt++. Next cycle rd_valid=1 and rd_data=ram_q.
  - In all other MIX cycles ram_address = hold register. The RAM re-registers its address every cycle, so this keeps rd_data stable while rd_valid&!rd_ready.
  - On rd_valid&rd_ready: rcnt++. rd_valid clears next cycle unless a new index was accepted in the same cycle.
  - Read-handshake latency: index accept in cycle t -> rd_valid in t+1.
  - The read handshake with rcnt==N-1 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 in DONE.
- Outside FILL/MIX, ram_address = hold register and all ready outputs are 0.
- Counters are ADDRBITS+1 bits wide with no wrap. Indices repeat freely, and any address order is legal in MIX.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- start while busy: ignored, no effect on counters.

Test Plan:
- ADDRBITS=3, start, write 8 words 0x..00..0x..07 with wr_valid held -> ram_wren high 8 consecutive cycles, addresses 0..7, busy=1. MIX entered the cycle after the 8th write.
- MIX with idx sequence 7,0,3,3,5,1,6,2 and rd_ready=1 -> rd_data = word[idx] one cycle after each accept, back-to-back. done pulses once, then busy=0.
- rd_ready low for 3 cycles while rd_valid -> idx_ready=0, ram_address frozen at last idx, rd_data stable. Releasing rd_ready resumes with no lost or duplicated read.
- wr_valid toggling 1,0,1,0 in FILL -> writes only on valid cycles, wcnt ends at 8 after 8 valid cycles, no extra ram_wren.
- abort in MIX after 3 reads -> IDLE next cycle, rd_valid=0, no done pulse. A new start runs FILL from address 0.
- reset_n pulsed low mid-FILL (async, between edges) -> all outputs 0 immediately, IDLE. start pulses while busy -> ignored, wcnt unaffected.
